// File: rtl/instruction_fetch_pkg.sv
// Shared widths and fetch FSM encoding, visible to pipeline control so it can
// decode the fetch state directly.
package instruction_fetch_pkg;

    localparam int CFG_GR_SIZE     = 32;
    localparam int CFG_XLEN        = CFG_GR_SIZE;
    localparam int CFG_INSTR_W     = 32;
    localparam int CFG_INSTR_BYTES = CFG_INSTR_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FULL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: single-outstanding request, data valid with ack.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int XLEN    = CFG_XLEN,
    parameter int INSTR_W = CFG_INSTR_W
) ();

    logic               mem_req;
    logic [XLEN-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding memory read, one-entry instruction buffer for
// decode, doNext pulse back to the instruction pointer, flush/redirect handling.
//
// state | meaning
// IDLE  | no request outstanding, buffer empty
// REQ   | read outstanding; r_kill marks it as flushed, data to be dropped
// FULL  | buffer holds an instruction for decode
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int XLEN    = CFG_XLEN,
    parameter int INSTR_W = CFG_INSTR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pc,
    input  logic                fetch_en,
    input  logic                flush,
    instruction_fetch_if.master mem,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [XLEN-1:0]     instr_pc,
    input  logic                instr_ready,
    output logic                pc_next,
    output logic [XLEN-1:0]     pc_adj,
    output logic                busy
);

    fetch_state_t       r_state,       w_state_nxt;
    logic               r_mem_req,     w_mem_req_nxt;
    logic [XLEN-1:0]    r_mem_addr,    w_mem_addr_nxt;
    logic               r_instr_valid, w_instr_valid_nxt;
    logic [INSTR_W-1:0] r_instr,       w_instr_nxt;
    logic [XLEN-1:0]    r_instr_pc,    w_instr_pc_nxt;
    logic               r_pc_next,     w_pc_next_nxt;
    logic               r_kill,        w_kill_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_pc_next     <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_pc_next     <= w_pc_next_nxt;
            r_kill        <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_pc_next_nxt     = 1'b0;
        w_kill_nxt        = r_kill;
        case (r_state)
            ST_IDLE: begin
                if (fetch_en && !flush) begin
                    w_mem_addr_nxt = pc;
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_kill_nxt    = 1'b0;
                    if (r_kill || flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_instr_nxt       = mem.mem_rdata;
                        w_instr_pc_nxt    = r_mem_addr;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_next_nxt     = 1'b1;
                        w_state_nxt       = ST_FULL;
                    end
                end else if (flush) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end else if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    // While pc_next is still high the pointer has not advanced
                    // yet; re-issue from IDLE next cycle so the new PC is used.
                    if (fetch_en && !r_pc_next) begin
                        w_mem_addr_nxt = pc;
                        w_mem_req_nxt  = 1'b1;
                        w_state_nxt    = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign instr_valid  = r_instr_valid;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign pc_next      = r_pc_next;
    assign pc_adj       = XLEN'(INSTR_W / 8);
    assign busy         = (r_state != ST_IDLE);

endmodule
